// File: rtl/timer_counter_if.sv
// CPU bridge side of the timer: word offset, write strobe/data, read mux data and interrupt.
interface timer_counter_if;
  logic [2:0]  ADDR;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  modport master (output ADDR, WE, WD, input RD, IRQ);
  modport slave  (input ADDR, WE, WD, output RD, IRQ);
endinterface

// File: rtl/timer_counter.sv
// Down-counting bus timer with one-shot (sticky IRQ) and auto-reload (1-cycle IRQ) modes.
// Optional prescaler selected by defining TIMER_PRESCALE_EN (PRESCALE_DIV cycles per decrement).
module timer_counter #(
  parameter int PRESCALE_DIV = 4
) (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_pend;

  logic        w_en;
  logic [1:0]  w_mode;
  logic        w_im;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_tick;

  assign w_en        = r_ctrl[0];
  assign w_mode      = r_ctrl[2:1];
  assign w_im        = r_ctrl[3];
  assign w_wr_ctrl   = bus.WE && (bus.ADDR == 3'b000);
  assign w_wr_preset = bus.WE && (bus.ADDR == 3'b001);

`ifdef TIMER_PRESCALE_EN
  localparam int PSC_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  logic [PSC_W-1:0] r_psc;

  assign w_tick = (r_psc == PSC_W'(PRESCALE_DIV - 1));

  // Prescaler only advances while counting so every count period starts aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_psc <= '0;
    else if (r_state != S_CNT) r_psc <= '0;
    else if (w_tick)           r_psc <= '0;
    else                       r_psc <= r_psc + 1'b1;
  end
`else
  logic [31:0] w_unused_div;
  assign w_unused_div = 32'(PRESCALE_DIV);
  assign w_tick       = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_en) r_state <= S_LOAD;
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!w_en) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            // Treat 0 like 1 so PRESET=0 still expires and COUNT never wraps.
            if (r_count <= 32'd1) begin
              r_count <= '0;
              r_state <= S_INT;
            end else begin
              r_count <= r_count - 32'd1;
            end
          end
        end
        S_INT: begin
          if (w_mode == 2'b01) begin
            r_state <= S_LOAD;
          end else begin
            r_ctrl[0]  <= 1'b0;
            r_irq_pend <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // CPU writes come last so they win over same-edge FSM updates.
      if (w_wr_ctrl)                 r_ctrl     <= bus.WD[3:0];
      if (w_wr_preset)               r_preset   <= bus.WD;
      if (w_wr_ctrl || w_wr_preset)  r_irq_pend <= 1'b0;
    end
  end

  always_comb begin
    bus.RD = '0;
    case (bus.ADDR)
      3'b000:  bus.RD = {28'd0, r_ctrl};
      3'b001:  bus.RD = r_preset;
      3'b010:  bus.RD = r_count;
      default: bus.RD = '0;
    endcase
  end

  assign bus.IRQ = w_im & (r_irq_pend | ((r_state == S_INT) && (w_mode == 2'b01)));
endmodule
